icache_controller: RTL and testbench
====================================

Name: icache_controller

Overview:
- Direct-mapped instruction cache controller between the CPU fetch stage and the 16-byte-block instruction memory.
- Serves 32-bit instruction words to the CPU from an internal 8-line block store.
- On a miss, it sequences a block read from instruction memory using the read/busywait handshake and refills the line.
- Stalls the CPU through busywait until the refilled word is available.

Parameters:
- ADDR_W, 10, CPU byte address width (1 KB instruction space).
- NUM_LINES, 8, number of cache lines; index width = log2(NUM_LINES) = 3.
- BLOCK_W, 128, line and memory block width in bits (16 bytes).

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- read  input  1  CPU fetch request.
- address  input  10  CPU byte address (PC). Fields: tag = [9:7], index = [6:4], word offset = [3:2]; [1:0] ignored.
- readinst  output  32  fetched instruction word.
- busywait  output  1  CPU stall.
- mem_read  output  1  block read request to instruction memory.
- mem_address  output  6  block address = {tag, index}.
- mem_readdata  input  128  block from memory; byte 0 in [7:0].
- mem_busywait  input  1  memory busy; rises with mem_read and falls when mem_readdata is valid.

Behaviour:
- Storage per line: 1 valid bit, 3-bit tag, 128-bit data. On reset all valid bits are cleared; data and tag contents are don't-care.
- Reset values: state = IDLE, mem_read = 0, mem_address = 0, busywait = 0, internal miss latch = 0.
- Hit (combinational): hit = read & valid[index] & (tag_store[index] == tag).
- readinst = word[offset] of line[index] when hit, else 32'h0. Word mapping: offset 0 = bits [31:0], 1 = [63:32], 2 = [95:64], 3 = [127:96].
- busywait (combinational) = read & ~hit in IDLE; = 1 in MEM_READ and UPDATE; = 0 otherwise.
- Hit latency is zero cycles; no state change on a hit.
- FSM states: IDLE, MEM_READ, UPDATE.
- IDLE -> MEM_READ at a clock edge where read & ~hit. The controller latches {tag, index} into miss_addr at that edge.
- MEM_READ:
  - mem_read = 1, mem_address = miss_addr.
  - A seen_busy flag sets at the first edge that samples mem_busywait = 1.
  - Transition to UPDATE at the first edge with seen_busy = 1 and mem_busywait = 0.
  - mem_readdata is captured into line[miss_addr index] at that same edge.
- UPDATE (exactly one cycle):
  - mem_read = 0; valid[index] <= 1; tag[index] <= miss tag; seen_busy cleared.
  - Next state IDLE, where the current address is re-evaluated (normally a hit).
- Miss penalty: memory latency + 2 cycles. busywait stays high continuously from miss detection until the IDLE cycle that hits.
- Address or read changing during MEM_READ or UPDATE is ignored; the fill always uses miss_addr. A read dropped mid-fill still completes the fill.
- A conflict miss (same index, different tag) overwrites the line; there is no writeback because the cache is read-only.
- Async reset mid-fill: immediate return to IDLE, mem_read drops, all lines invalid, in-flight data discarded. A subsequent busywait fall from memory is ignored.
- mem_read is never asserted in IDLE. It holds a stable value and stable mem_address throughout MEM_READ.
- read = 0 in IDLE: busywait = 0, readinst = 0, no transition.

Test Plan:
- Reset with reset = 0 and read = 1, address = 10'h000 -> busywait = 0, mem_read = 0. Release reset -> miss; mem_read = 1, mem_address = 6'd0 until fill; UPDATE, then IDLE hit with readinst = 32'h05000002, busywait = 0.
- After the block-0 fill, address sweep 10'h004, 10'h008, 10'h00C -> each a zero-wait hit returning 32'h05010002, 32'h04020001, 32'h06010000. mem_read stays 0.
- address = 10'h014 (block 1, offset 1) -> miss, mem_address = 6'd1, then readinst = 32'h07FE0001. Re-reading 10'h010 -> hit, 32'h01000001.
- Conflict: fill 10'h000, then fetch 10'h080 (same index 0, tag 1) -> miss, mem_address = 6'd8, line replaced. Fetch 10'h000 again -> miss, mem_address = 6'd0.
- During MEM_READ for 10'h020, switch address to 10'h3F0 -> mem_address stays 6'd2 until fill. Line 2 is then valid; next IDLE misses on 10'h3F0 with mem_address = 6'd63.
- Assert reset mid-MEM_READ -> mem_read and busywait drop asynchronously. After release, fetch of the previously filled 10'h000 misses (all lines invalid).

Source files
------------

// File: rtl/icache_controller.sv
// icache_controller
//   Direct-mapped, read-only instruction cache between the CPU fetch stage
//   and a 16-byte-block instruction memory. Hits return the selected word in
//   the same cycle. A miss runs a block read over the read/busywait
//   handshake, refills the line and stalls the CPU until the word is valid.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-low reset
//   read         CPU fetch request
//   address      CPU byte address: tag [9:7], index [6:4], word [3:2]
//   readinst     fetched instruction word (0 when not a hit)
//   busywait     CPU stall
//   mem_read     block read request to instruction memory
//   mem_address  block address {tag, index}
//   mem_readdata block from memory, byte 0 in [7:0]
//   mem_busywait memory busy; falls when mem_readdata is valid
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | serving hits; a miss latches {tag,index} and starts a read
// MEM_READ | mem_read held; waits for busywait to rise and fall, then
//          | captures the block into the missed line
// UPDATE   | one cycle: mark the line valid with the missed tag
module icache_controller #(
  parameter int ADDR_W    = 10,
  parameter int NUM_LINES = 8,
  parameter int BLOCK_W   = 128
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                read,
  input  logic [ADDR_W-1:0]   address,
  output logic [31:0]         readinst,
  output logic                busywait,
  output logic                mem_read,
  output logic [ADDR_W-5:0]   mem_address,
  input  logic [BLOCK_W-1:0]  mem_readdata,
  input  logic                mem_busywait
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - 4 - IDX_W;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t                 state;
  logic [NUM_LINES-1:0]   valid;
  logic [TAG_W-1:0]       tag_store  [NUM_LINES];
  logic [BLOCK_W-1:0]     data_store [NUM_LINES];
  logic [ADDR_W-5:0]      miss_addr;
  logic                   seen_busy;

  logic [TAG_W-1:0]       tag;
  logic [IDX_W-1:0]       index;
  logic [1:0]             offset;
  logic [TAG_W-1:0]       miss_tag;
  logic [IDX_W-1:0]       miss_index;
  logic                   hit;
  logic                   fill_done;

  assign tag        = address[ADDR_W-1 -: TAG_W];
  assign index      = address[4 +: IDX_W];
  assign offset     = address[3:2];
  assign miss_tag   = miss_addr[IDX_W +: TAG_W];
  assign miss_index = miss_addr[IDX_W-1:0];

  assign hit       = read & valid[index] & (tag_store[index] == tag);
  assign readinst  = hit ? data_store[index][{offset, 5'b0} +: 32] : 32'h0;
  // The block is only trusted once busywait has been seen high, so a stale
  // low level at the start of the request is not taken as "data ready".
  assign fill_done = (state == MEM_READ) & seen_busy & ~mem_busywait;

  // Gated by reset so the stall drops immediately while reset is held.
  always_comb begin
    busywait = 1'b0;
    case (state)
      IDLE:     busywait = read & ~hit;
      MEM_READ: busywait = 1'b1;
      UPDATE:   busywait = 1'b1;
      default:  busywait = 1'b0;
    endcase
    busywait = busywait & reset;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      mem_read    <= 1'b0;
      mem_address <= '0;
      miss_addr   <= '0;
      seen_busy   <= 1'b0;
      valid       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read && !hit) begin
            miss_addr   <= {tag, index};
            mem_address <= {tag, index};
            mem_read    <= 1'b1;
            state       <= MEM_READ;
          end
        end
        MEM_READ: begin
          if (mem_busywait) begin
            seen_busy <= 1'b1;
          end else if (seen_busy) begin
            mem_read <= 1'b0;
            state    <= UPDATE;
          end
        end
        UPDATE: begin
          valid[miss_index] <= 1'b1;
          seen_busy         <= 1'b0;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data contents need no reset: valid bits gate every use.
  always_ff @(posedge clock) begin
    if (fill_done) begin
      data_store[miss_index] <= mem_readdata;
    end
    if (state == UPDATE) begin
      tag_store[miss_index] <= miss_tag;
    end
  end

endmodule

// File: tb/tb_icache_controller.sv
module tb_icache_controller;

  logic         clock = 1'b0;
  logic         reset;
  logic         read;
  logic [9:0]   address;
  logic [31:0]  readinst;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata = '0;
  logic         mem_busywait = 1'b0;

  icache_controller dut (
    .clock        (clock),
    .reset        (reset),
    .read         (read),
    .address      (address),
    .readinst     (readinst),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference: block memory contents plus which block each line holds.
  logic [127:0] mem_blk [64];
  bit           ref_valid [8];
  logic [2:0]   ref_tag [8];

  // Memory responder: on a request, busy for lat cycles, then data + busy low.
  // From mem_read rising to data valid is lat+1 cycles, so the CPU sees a
  // stall of lat+3 cycles (memory latency + 2).
  int mem_cnt = 0;
  int last_lat = 0;
  bit mem_active = 0;

  always @(negedge clock or negedge reset) begin
    if (!reset) begin
      mem_busywait = 1'b0;
      mem_active   = 0;
    end else if (mem_active) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_readdata = mem_blk[mem_address];
        mem_busywait = 1'b0;
        mem_active   = 0;
      end
    end else if (mem_read) begin
      mem_active   = 1;
      mem_busywait = 1'b1;
      mem_cnt      = $urandom_range(1, 4);
      last_lat     = mem_cnt;
      mem_readdata = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [9:0] a);
    logic [127:0] b;
    b = mem_blk[a[9:4]];
    return b[a[3:2]*32 +: 32];
  endfunction

  // Called with the miss already visible in IDLE; waits for the hit.
  task automatic wait_fill(input logic [9:0] a);
    int cyc;
    bit done;
    cyc  = 0;
    done = 0;
    while (!done && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
      if (mem_read) chk("mem_addr", mem_address, a[9:4]);
      if (!busywait) done = 1;
    end
    chk("fill_done", done, 1);
    chk("penalty", cyc, last_lat + 3);
    chk("fill_data", readinst, exp_word(a));
    chk("fill_memrd", mem_read, 0);
    ref_valid[a[6:4]] = 1;
    ref_tag[a[6:4]]   = a[9:7];
  endtask

  task automatic fetch(input logic [9:0] a);
    bit hit;
    hit = ref_valid[a[6:4]] && (ref_tag[a[6:4]] == a[9:7]);
    @(negedge clock);
    read = 1'b1;
    address = a;
    #1;
    if (hit) begin
      chk("hit_busy", busywait, 0);
      chk("hit_data", readinst, exp_word(a));
      chk("hit_memrd", mem_read, 0);
    end else begin
      chk("miss_busy", busywait, 1);
      wait_fill(a);
    end
  endtask

  task automatic idle_check();
    @(negedge clock);
    read = 1'b0;
    address = 10'($urandom);
    #1;
    chk("noread_busy", busywait, 0);
    chk("noread_data", readinst, 0);
    @(posedge clock); #1;
    chk("noread_memrd", mem_read, 0);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 64; i++) mem_blk[i] = {$urandom, $urandom, $urandom, $urandom};
    mem_blk[0] = {32'h06010000, 32'h04020001, 32'h05010002, 32'h05000002};
    mem_blk[1][63:0] = {32'h07FE0001, 32'h01000001};
    for (int i = 0; i < 8; i++) ref_valid[i] = 0;

    // Reset held with a fetch pending: no stall, no memory request.
    reset = 1'b0;
    read = 1'b1;
    address = 10'h000;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busywait, 0);
    chk("rst_memrd", mem_read, 0);
    chk("rst_memaddr", mem_address, 0);
    chk("rst_data", readinst, 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("first_miss_busy", busywait, 1);
    wait_fill(10'h000);
    chk("blk0_w0", readinst, 32'h05000002);

    fetch(10'h004); chk("blk0_w1", readinst, 32'h05010002);
    fetch(10'h008); chk("blk0_w2", readinst, 32'h04020001);
    fetch(10'h00C); chk("blk0_w3", readinst, 32'h06010000);

    fetch(10'h014); chk("blk1_w1", readinst, 32'h07FE0001);
    fetch(10'h010); chk("blk1_w0", readinst, 32'h01000001);

    idle_check();

    // Conflict on index 0.
    fetch(10'h080);
    fetch(10'h000); chk("blk0_refill", readinst, 32'h05000002);

    // Address moves away mid-fill; the fill still targets block 2.
    @(negedge clock);
    read = 1'b1;
    address = 10'h020;
    #1;
    chk("sw_miss_busy", busywait, 1);
    @(posedge clock); #1;
    chk("sw_memrd", mem_read, 1);
    chk("sw_memaddr0", mem_address, 6'd2);
    @(negedge clock);
    address = 10'h3F0;
    cyc = 0;
    while (mem_read && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
      if (mem_read) chk("sw_memaddr", mem_address, 6'd2);
      chk("sw_busy", busywait, 1);
    end
    chk("sw_fill_ended", mem_read, 0);
    @(posedge clock); #1;
    chk("sw_remiss_busy", busywait, 1);
    chk("sw_remiss_memrd", mem_read, 0);
    ref_valid[2] = 1;
    ref_tag[2]   = 3'd0;
    wait_fill(10'h3F0);
    fetch(10'h028);

    // Randomised fetches over a few tags so hits and conflicts both occur.
    for (int n = 0; n < 80; n++) begin
      logic [9:0] a;
      a = {3'($urandom_range(0, 3)), 3'($urandom), 2'($urandom), 2'($urandom)};
      if ($urandom_range(0, 7) == 0) idle_check();
      fetch(a);
    end

    // Reset in the middle of a fill.
    fetch(10'h000);
    @(negedge clock);
    read = 1'b1;
    address = 10'h3D0;
    @(posedge clock); #1;
    chk("mid_memrd", mem_read, 1);
    @(negedge clock); #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_memrd", mem_read, 0);
    chk("mid_rst_busy", busywait, 0);
    chk("mid_rst_data", readinst, 0);
    for (int i = 0; i < 8; i++) ref_valid[i] = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    read = 1'b0;
    reset = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    chk("post_rst_memrd", mem_read, 0);
    fetch(10'h000);
    chk("post_rst_data", readinst, 32'h05000002);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
